// File: rtl/lr_dma_arbiter.sv
// lr_dma_arbiter: owns the OAM DMA register and sequences the 160-byte OAM copy.
//   It also arbitrates the low bus (0x0000-0xFEFF) between the CPU and the DMA engine.
// Latency: the first OAM write lands START_DELAY+1 cycles after the posedge that samples
//   the DMA register store. After that, the engine makes one OAM write per cycle.
// Backpressure: none on the high page. CPU low-page accesses during XFER are blocked:
//   reads return 8'hFF and stores are dropped. When DMA_CPU_PRIORITY_EN is defined,
//   the CPU access wins that slot and the DMA slot stalls instead.
// Ports: clock4/resetn (async active-low); cpu_* is the CPU side; mem_* is the low bus;
//   hi_* is the 0xFF00-0xFFFF page (always CPU-owned); oam_* is the OAM write port;
//   dma_active is high while a copy is in progress.
// Optional feature macro: DMA_CPU_PRIORITY_EN.
module lr_dma_arbiter #(
  parameter int          DMA_LEN     = 160,
  parameter int          START_DELAY = 1,
  parameter logic [15:0] DMA_REG     = 16'hFF46
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_outdata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [7:0]  cpu_indata,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_load,
  output logic        mem_store,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  hi_address,
  output logic [7:0]  hi_wdata,
  output logic        hi_load,
  output logic        hi_store,
  input  logic [7:0]  hi_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  localparam int CW = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t          state, state_nxt;
  logic [7:0]      src;
  logic [7:0]      idx;
  logic [CW-1:0]   start_cnt;

  logic            is_dma_reg, is_hi, is_lo;
  logic            dma_wr;
  logic            stall;
  logic            slot;
  logic [7:0]      eff_src;

  assign is_dma_reg = (cpu_address == DMA_REG);
  assign is_hi      = (cpu_address[15:8] == 8'hFF) && !is_dma_reg;
  assign is_lo      = (cpu_address[15:8] != 8'hFF);
  assign dma_wr     = cpu_store && is_dma_reg;

  // 0xE0xx-0xFFxx sources read through the echo of work RAM.
  assign eff_src    = (src < 8'hE0) ? src : (src - 8'h20);

`ifdef DMA_CPU_PRIORITY_EN
  assign stall = (state == XFER) && is_lo && (cpu_load || cpu_store);
`else
  assign stall = 1'b0;
`endif

  assign slot       = (state == XFER) && !stall;
  assign dma_active = (state == XFER);

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      START:   if (start_cnt <= CW'(1)) state_nxt = XFER;
      XFER:    if (slot && (idx == LAST_IDX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A register write restarts from any state. The current slot still completes,
    // because the OAM write is combinational within this cycle.
    if (dma_wr) state_nxt = START;
  end

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      src       <= 8'hFF;
      idx       <= 8'h00;
      start_cnt <= '0;
    end else begin
      if (dma_wr) begin
        src       <= cpu_outdata;
        idx       <= 8'h00;
        start_cnt <= CW'(START_DELAY);
      end else begin
        if (slot) idx <= (idx == LAST_IDX) ? 8'h00 : idx + 8'h01;
        if ((state == START) && (start_cnt != '0)) start_cnt <= start_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    mem_address = 16'h0000;
    mem_wdata   = 8'h00;
    mem_load    = 1'b0;
    mem_store   = 1'b0;
    oam_addr    = 8'h00;
    oam_wdata   = 8'h00;
    oam_we      = 1'b0;
    hi_address  = cpu_address[7:0];
    hi_wdata    = cpu_outdata;
    hi_load     = cpu_load && is_hi;
    hi_store    = cpu_store && is_hi;

    if (slot) begin
      mem_address = {eff_src, idx};
      mem_load    = 1'b1;
      oam_addr    = idx;
      oam_wdata   = mem_rdata;
      oam_we      = 1'b1;
    end else if (is_lo) begin
      mem_address = cpu_address;
      mem_wdata   = cpu_outdata;
      mem_load    = cpu_load;
      mem_store   = cpu_store;
    end

    if (is_dma_reg)  cpu_indata = src;
    else if (is_hi)  cpu_indata = hi_rdata;
    else if (slot)   cpu_indata = 8'hFF;  // bus is owned by the DMA slot
    else             cpu_indata = mem_rdata;
  end

endmodule

// File: tb/tb_lr_dma_arbiter.sv
// tb_lr_dma_arbiter: randomized CPU traffic against a cycle-indexed model of the OAM copy.
// Latency: expectations are checked mid-cycle; the model advances at each posedge.
// Backpressure: the model predicts blocking (or CPU priority when the macro is defined).
module tb_lr_dma_arbiter;

  localparam int DMA_LEN     = 160;
  localparam int START_DELAY = 1;
`ifdef DMA_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clock4 = 1'b0;
  logic        resetn;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_outdata;
  logic        cpu_load, cpu_store;
  logic [7:0]  cpu_indata;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_load, mem_store;
  logic [7:0]  mem_rdata;
  logic [7:0]  hi_address, hi_wdata;
  logic        hi_load, hi_store;
  logic [7:0]  hi_rdata;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we, dma_active;

  always #5 clock4 = ~clock4;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] hi_fn(input logic [7:0] a);
    return ~a + 8'h11;
  endfunction

  function automatic logic [7:0] eff_hi(input logic [7:0] s);
    return (s < 8'hE0) ? s : s - 8'h20;
  endfunction

  assign mem_rdata = mem_fn(mem_address);
  assign hi_rdata  = hi_fn(hi_address);

  lr_dma_arbiter dut (
    .clock4(clock4), .resetn(resetn),
    .cpu_address(cpu_address), .cpu_outdata(cpu_outdata),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_indata(cpu_indata),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_store(mem_store), .mem_rdata(mem_rdata),
    .hi_address(hi_address), .hi_wdata(hi_wdata),
    .hi_load(hi_load), .hi_store(hi_store), .hi_rdata(hi_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .dma_active(dma_active)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: a copy is "armed" with a first-slot cycle number and a byte count.
  bit         m_armed = 1'b0;
  int         m_go    = 0;
  int         m_pos   = 0;
  logic [7:0] m_src   = 8'hFF;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic step(input logic ld, input logic st, input logic [15:0] a, input logic [7:0] d);
    logic dreg, hi, lo, act, stall, slot;
    logic [15:0] ea;
    logic [7:0]  rd;
    @(negedge clock4);
    cpu_load = ld; cpu_store = st; cpu_address = a; cpu_outdata = d;
    #1;
    dreg  = (a == 16'hFF46);
    hi    = (a[15:8] == 8'hFF) && !dreg;
    lo    = (a[15:8] != 8'hFF);
    act   = m_armed && (cyc >= m_go) && (m_pos < DMA_LEN);
    stall = PRIO && act && lo && (ld || st);
    slot  = act && !stall;
    check_val("dma_active", {15'd0, dma_active}, {15'd0, act});
    check_val("oam_we", {15'd0, oam_we}, {15'd0, slot});
    if (slot) begin
      ea = {eff_hi(m_src), m_pos[7:0]};
      check_val("dma_addr", mem_address, ea);
      check_val("dma_load", {15'd0, mem_load}, 16'd1);
      check_val("oam_addr", {8'd0, oam_addr}, {8'd0, m_pos[7:0]});
      check_val("oam_wdata", {8'd0, oam_wdata}, {8'd0, mem_fn(ea)});
    end else begin
      check_val("mem_addr", mem_address, lo ? a : 16'h0000);
      check_val("mem_load", {15'd0, mem_load}, {15'd0, ld && lo});
    end
    check_val("mem_store", {15'd0, mem_store}, {15'd0, !slot && lo && st});
    check_val("hi_load", {15'd0, hi_load}, {15'd0, ld && hi});
    check_val("hi_store", {15'd0, hi_store}, {15'd0, st && hi});
    if (ld) begin
      if (dreg)              rd = m_src;
      else if (hi)           rd = hi_fn(a[7:0]);
      else if (act && !PRIO) rd = 8'hFF;
      else                   rd = mem_fn(a);
      check_val("cpu_indata", {8'd0, cpu_indata}, {8'd0, rd});
    end
    @(posedge clock4);
    cyc++;
    if (slot) m_pos++;
    if (st && dreg) begin
      m_src   = d;
      m_pos   = 0;
      m_go    = cyc + START_DELAY;
      m_armed = 1'b1;
    end
  endtask

  task automatic step_random(input bit allow_dma);
    int r;
    logic [15:0] a;
    r = $urandom_range(0, 9);
    case (r)
      3, 4: step(1'b1, 1'b0, 16'($urandom_range(0, 16'hFEFF)), 8'h00);
      5:    step(1'b0, 1'b1, 16'($urandom_range(0, 16'hFEFF)), 8'($urandom));
      6, 7: begin
        a = 16'hFF00 | 16'($urandom_range(0, 255));
        if (a == 16'hFF46) a = 16'hFF47;
        if (r == 6) step(1'b1, 1'b0, a, 8'h00);
        else        step(1'b0, 1'b1, a, 8'($urandom));
      end
      8: step(1'b1, 1'b0, 16'hFF46, 8'h00);
      9: begin
        if (allow_dma && ($urandom_range(0, 29) == 0)) step(1'b0, 1'b1, 16'hFF46, 8'($urandom));
        else step(1'b0, 1'b0, 16'h0000, 8'h00);
      end
      default: step(1'b0, 1'b0, 16'h0000, 8'h00);
    endcase
  endtask

  task automatic run_random(input int n, input bit allow_dma);
    for (int i = 0; i < n; i++) step_random(allow_dma);
  endtask

  task automatic run_until_pos(input int target);
    for (int i = 0; i < 400 && m_pos != target; i++) step_random(1'b0);
    check_val("reach_pos", 16'(m_pos), 16'(target));
  endtask

  initial begin
    resetn = 1'b0;
    cpu_address = 16'h0000; cpu_outdata = 8'h00; cpu_load = 1'b0; cpu_store = 1'b0;
    #1;
    check_val("rst_dma_active", {15'd0, dma_active}, 16'd0);
    check_val("rst_oam_we", {15'd0, oam_we}, 16'd0);
    check_val("rst_mem_addr", mem_address, 16'h0000);
    check_val("rst_oam_addr", {8'd0, oam_addr}, 16'd0);
    check_val("rst_mem_load", {15'd0, mem_load}, 16'd0);
    #20;
    @(negedge clock4);
    resetn = 1'b1;

    step(1'b1, 1'b0, 16'hFF46, 8'h00);          // reads 8'hFF after reset
    step(1'b0, 1'b1, 16'hFF46, 8'hC1);
    run_random(170, 1'b0);
    step(1'b1, 1'b0, 16'hFF46, 8'h00);          // reads back 8'hC1

    step(1'b0, 1'b1, 16'hFF46, 8'hE3);          // echo source -> 0xC3xx
    run_random(170, 1'b0);

    step(1'b0, 1'b1, 16'hFF46, 8'h11);
    run_random(5, 1'b0);
    step(1'b1, 1'b0, 16'h1234, 8'h00);
    step(1'b0, 1'b1, 16'hC000, 8'h77);
    step(1'b1, 1'b0, 16'hFF85, 8'h00);
    run_random(170, 1'b0);

    step(1'b0, 1'b1, 16'hFF46, 8'hA0);          // restart mid-transfer
    run_until_pos(8'h50);
    step(1'b0, 1'b1, 16'hFF46, 8'hC2);
    run_random(170, 1'b0);

    step(1'b0, 1'b1, 16'hFF46, 8'hC3);          // restart in the final slot
    run_until_pos(DMA_LEN - 1);
    step(1'b0, 1'b1, 16'hFF46, 8'hD4);
    run_random(170, 1'b0);

    step(1'b0, 1'b1, 16'hFF46, 8'h80);          // reset mid-transfer
    run_until_pos(8'h20);
    @(negedge clock4);
    cpu_load = 1'b0; cpu_store = 1'b0; cpu_address = 16'h0000;
    #2;
    resetn = 1'b0;
    #1;
    check_val("midrst_dma_active", {15'd0, dma_active}, 16'd0);
    check_val("midrst_oam_we", {15'd0, oam_we}, 16'd0);
    check_val("midrst_mem_load", {15'd0, mem_load}, 16'd0);
    m_armed = 1'b0; m_pos = 0; m_src = 8'hFF;
    repeat (2) @(posedge clock4);
    #1;
    check_val("midrst_oam_we_held", {15'd0, oam_we}, 16'd0);
    @(negedge clock4);
    resetn = 1'b1;
    step(1'b1, 1'b0, 16'hFF46, 8'h00);          // reads 8'hFF again
    run_random(10, 1'b0);

    run_random(3000, 1'b1);
    run_random(400, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
